// File: rtl/cu_mc_ext.sv
// Multicycle RV32I control unit: registered-output FSM with AUIPC, full branch set and a
// ready/valid data-memory wait. Define ILLEGAL_TRAP_EN to trap on illegal decode or memory timeout.
module cu_mc_ext #(
    parameter int                  ALU_OP_W    = 4,
    parameter logic [ALU_OP_W-1:0] ALU_ADD     = 4'b0000,
    parameter logic [ALU_OP_W-1:0] ALU_SUB     = 4'b1000,
    parameter int                  MEM_TIMEOUT = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                is_r,
    input  logic                is_imm,
    input  logic                is_lui,
    input  logic                is_auipc,
    input  logic                is_load,
    input  logic                is_store,
    input  logic                is_jal,
    input  logic                is_jalr,
    input  logic                is_branch,
    input  logic [2:0]          funct3,
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic [3:0]          fr,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc0_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic                mem_req,
    output logic                mem_write,
    output logic                rs1_pc_s,
    output logic                rs2_imm_s,
    output logic [1:0]          w_data_s,
    output logic [1:0]          pc_s,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic                instr_done,
    output logic                trap
);
    typedef enum logic [4:0] {
        IDLE, FETCH, DECODE, EXE_R, EXE_I, AUIPC_EX, WB_ALU, LUI_WB, ADDR,
        LD_WAIT, LD_WB, ST_WAIT, JAL, JALR, BR_CMP, BR_DO, TRAP
    } state_t;

    state_t st, nxt;
    logic any_type, taken, timeout, nop_done, done_q;
    logic nx_pc_write, nx_pc0_write, nx_ir_write, nx_reg_write, nx_mem_req, nx_mem_write;
    logic nx_rs1_pc_s, nx_rs2_imm_s, nx_done;
    logic [1:0] nx_w_data_s, nx_pc_s;
    logic [ALU_OP_W-1:0] nx_alu_op;

    assign any_type = is_r | is_imm | is_lui | is_auipc | is_load | is_store
                    | is_jal | is_jalr | is_branch;

    // fr = {ZF, SF, CF, OF}; flags come from the BR_CMP subtraction
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = fr[3];
            3'b001:  taken = !fr[3];
            3'b100:  taken = fr[2] ^ fr[0];
            3'b101:  taken = !(fr[2] ^ fr[0]);
            3'b110:  taken = fr[1];
            3'b111:  taken = !fr[1];
            default: taken = 1'b0;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    if (MEM_TIMEOUT > 0) begin : g_tmo
        localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
        logic [CW-1:0] wait_cnt;
        logic          in_wait;
        assign in_wait = (st == LD_WAIT) || (st == ST_WAIT);
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                     wait_cnt <= '0;
            else if (in_wait && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
            else                            wait_cnt <= '0;
        end
        assign timeout = in_wait && !mem_ready && (wait_cnt == CW'(MEM_TIMEOUT - 1));
    end else begin : g_no_tmo
        assign timeout = 1'b0;
    end
    assign nop_done = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) trap <= 1'b0;
        else        trap <= (nxt == TRAP);
    end
`else
    assign timeout  = 1'b0;
    assign nop_done = (st == DECODE) && !any_type;
    assign trap     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= IDLE;
        else        st <= nxt;
    end

    always_comb begin
        nxt = st;
        case (st)
            IDLE:   nxt = FETCH;
            FETCH:  nxt = DECODE;
            DECODE: begin
                if (is_lui)                          nxt = LUI_WB;
                else if (is_jal)                     nxt = JAL;
                else if (is_auipc)                   nxt = AUIPC_EX;
                else if (is_r)                       nxt = EXE_R;
                else if (is_imm)                     nxt = EXE_I;
                else if (is_branch)                  nxt = BR_CMP;
                else if (is_load | is_store | is_jalr) nxt = ADDR;
`ifdef ILLEGAL_TRAP_EN
                else                                 nxt = TRAP;
`else
                else                                 nxt = FETCH;
`endif
            end
            EXE_R, EXE_I, AUIPC_EX: nxt = WB_ALU;
            ADDR: begin
                if (is_load)       nxt = LD_WAIT;
                else if (is_store) nxt = ST_WAIT;
                else if (is_jalr)  nxt = JALR;
                else               nxt = FETCH;
            end
            LD_WAIT: if (mem_ready) nxt = LD_WB; else if (timeout) nxt = TRAP;
            ST_WAIT: if (mem_ready) nxt = FETCH; else if (timeout) nxt = TRAP;
            BR_CMP:  nxt = BR_DO;
            WB_ALU, LUI_WB, LD_WB, JAL, JALR, BR_DO: nxt = FETCH;
            TRAP:    nxt = TRAP;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the state about to be entered; selects hold unless overwritten
    always_comb begin
        nx_pc_write  = 1'b0;
        nx_pc0_write = 1'b0;
        nx_ir_write  = 1'b0;
        nx_reg_write = 1'b0;
        nx_mem_req   = 1'b0;
        nx_mem_write = 1'b0;
        nx_done      = 1'b0;
        nx_rs1_pc_s  = rs1_pc_s;
        nx_rs2_imm_s = rs2_imm_s;
        nx_w_data_s  = w_data_s;
        nx_pc_s      = pc_s;
        nx_alu_op    = alu_op_o;
        case (nxt)
            FETCH:    begin nx_pc_write = 1'b1; nx_pc0_write = 1'b1; nx_ir_write = 1'b1; nx_pc_s = 2'b00; end
            EXE_R:    begin nx_alu_op = alu_op;  nx_rs1_pc_s = 1'b0; nx_rs2_imm_s = 1'b0; end
            EXE_I:    begin nx_alu_op = alu_op;  nx_rs1_pc_s = 1'b0; nx_rs2_imm_s = 1'b1; end
            AUIPC_EX: begin nx_alu_op = ALU_ADD; nx_rs1_pc_s = 1'b1; nx_rs2_imm_s = 1'b1; end
            ADDR:     begin nx_alu_op = ALU_ADD; nx_rs1_pc_s = 1'b0; nx_rs2_imm_s = 1'b1; end
            BR_CMP:   begin nx_alu_op = ALU_SUB; nx_rs1_pc_s = 1'b0; nx_rs2_imm_s = 1'b0; end
            WB_ALU:   begin nx_reg_write = 1'b1; nx_w_data_s = 2'b00; nx_done = 1'b1; end
            LUI_WB:   begin nx_reg_write = 1'b1; nx_w_data_s = 2'b01; nx_done = 1'b1; end
            LD_WB:    begin nx_reg_write = 1'b1; nx_w_data_s = 2'b10; nx_done = 1'b1; end
            LD_WAIT:  nx_mem_req = 1'b1;
            ST_WAIT:  begin nx_mem_req = 1'b1; nx_mem_write = 1'b1; end
            JAL:      begin nx_pc_write = 1'b1; nx_reg_write = 1'b1; nx_w_data_s = 2'b11; nx_pc_s = 2'b01; nx_done = 1'b1; end
            JALR:     begin nx_pc_write = 1'b1; nx_reg_write = 1'b1; nx_w_data_s = 2'b11; nx_pc_s = 2'b10; nx_done = 1'b1; end
            BR_DO:    begin nx_pc_write = taken; nx_pc_s = 2'b01; nx_done = 1'b1; end
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_write  <= 1'b0; pc0_write <= 1'b0; ir_write  <= 1'b0; reg_write <= 1'b0;
            mem_req   <= 1'b0; mem_write <= 1'b0; rs1_pc_s  <= 1'b0; rs2_imm_s <= 1'b0;
            w_data_s  <= 2'b00; pc_s <= 2'b00; alu_op_o <= '0; done_q <= 1'b0;
        end else begin
            pc_write  <= nx_pc_write;  pc0_write <= nx_pc0_write;
            ir_write  <= nx_ir_write;  reg_write <= nx_reg_write;
            mem_req   <= nx_mem_req;   mem_write <= nx_mem_write;
            rs1_pc_s  <= nx_rs1_pc_s;  rs2_imm_s <= nx_rs2_imm_s;
            w_data_s  <= nx_w_data_s;  pc_s      <= nx_pc_s;
            alu_op_o  <= nx_alu_op;    done_q    <= nx_done;
        end
    end

    // Store completion and NOP retire are only known in the cycle itself
    assign instr_done = done_q | nop_done | ((st == ST_WAIT) && mem_ready);
endmodule

// File: tb/tb_cu_mc_ext.sv
// Scoreboard bench for cu_mc_ext: per-instruction cycle scripts queue expected outputs,
// a negedge monitor pops and compares every cycle.
module tb_cu_mc_ext;
`ifdef ILLEGAL_TRAP_EN
    localparam int TMO = 8;
    localparam bit TRAP_EN = 1'b1;
`else
    localparam int TMO = 0;
    localparam bit TRAP_EN = 1'b0;
`endif
    localparam int K_R = 0, K_I = 1, K_LUI = 2, K_AUIPC = 3, K_LD = 4,
                   K_ST = 5, K_JAL = 6, K_JALR = 7, K_BR = 8, K_NOP = 9;

    logic clk = 1'b0, rst_n = 1'b0;
    logic is_r, is_imm, is_lui, is_auipc, is_load, is_store, is_jal, is_jalr, is_branch;
    logic [2:0] funct3;
    logic [3:0] alu_op, fr;
    logic mem_ready;
    logic pc_write, pc0_write, ir_write, reg_write, mem_req, mem_write, rs1_pc_s, rs2_imm_s;
    logic [1:0] w_data_s, pc_s;
    logic [3:0] alu_op_o;
    logic instr_done, trap;

    typedef struct packed {
        logic pcw, pc0w, irw, rw, mreq, mwr, rs1, rs2;
        logic [1:0] wd, pcs;
        logic [3:0] alu;
        logic done, trap;
    } out_t;

    out_t  q[$];
    string tq[$];
    out_t  m, mon_e, mon_a;
    string mon_t;
    int    checks = 0, errors = 0;
    string nm[10] = '{"r", "imm", "lui", "auipc", "load", "store", "jal", "jalr", "branch", "nop"};

    cu_mc_ext #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .is_r(is_r), .is_imm(is_imm), .is_lui(is_lui), .is_auipc(is_auipc), .is_load(is_load),
        .is_store(is_store), .is_jal(is_jal), .is_jalr(is_jalr), .is_branch(is_branch),
        .funct3(funct3), .alu_op(alu_op), .fr(fr), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc0_write(pc0_write), .ir_write(ir_write), .reg_write(reg_write),
        .mem_req(mem_req), .mem_write(mem_write), .rs1_pc_s(rs1_pc_s), .rs2_imm_s(rs2_imm_s),
        .w_data_s(w_data_s), .pc_s(pc_s), .alu_op_o(alu_op_o),
        .instr_done(instr_done), .trap(trap)
    );

    always #5 clk = ~clk;

    function automatic string fmt(input out_t o);
        return $sformatf("en(pc,pc0,ir,reg,req,wr)=%b%b%b%b%b%b a_pc=%b b_imm=%b wd=%b pcs=%b alu=%b done=%b trap=%b",
                         o.pcw, o.pc0w, o.irw, o.rw, o.mreq, o.mwr, o.rs1, o.rs2, o.wd, o.pcs,
                         o.alu, o.done, o.trap);
    endfunction

    // Monitor: every cycle with a pending expectation is compared
    initial forever begin
        @(negedge clk);
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            mon_t = tq.pop_front();
            mon_a = {pc_write, pc0_write, ir_write, reg_write, mem_req, mem_write, rs1_pc_s,
                     rs2_imm_s, w_data_s, pc_s, alu_op_o, instr_done, trap};
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display("FAIL %s got %s want %s", mon_t, fmt(mon_a), fmt(mon_e));
            end
        end
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic [3:0] f);
        logic zf, sf, cf, of;
        {zf, sf, cf, of} = f;
        case (f3)
            3'd0: return zf;          // equal
            3'd1: return !zf;
            3'd4: return sf != of;    // signed less-than
            3'd5: return sf == of;
            3'd6: return cf;          // unsigned borrow
            3'd7: return !cf;
            default: return 1'b0;
        endcase
    endfunction

    function automatic out_t base();
        out_t b = m;
        b.pcw = 0; b.pc0w = 0; b.irw = 0; b.rw = 0; b.mreq = 0; b.mwr = 0; b.done = 0;
        return b;
    endfunction

    task automatic push(input out_t e, input string t);
        m = e;
        q.push_back(e);
        tq.push_back(t);
    endtask

    task automatic cyc(input out_t e, input logic rdy, input string t);
        @(posedge clk); #1;
        mem_ready = rdy;
        push(e, t);
    endtask

    task automatic set_type(input int k);
        {is_r, is_imm, is_lui, is_auipc, is_load, is_store, is_jal, is_jalr, is_branch} = '0;
        case (k)
            K_R: is_r = 1; K_I: is_imm = 1; K_LUI: is_lui = 1; K_AUIPC: is_auipc = 1;
            K_LD: is_load = 1; K_ST: is_store = 1; K_JAL: is_jal = 1; K_JALR: is_jalr = 1;
            K_BR: is_branch = 1; default: ;
        endcase
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 0; mem_ready = 0; m = '0;
        push('0, "reset");
        @(posedge clk); #1;
        rst_n = 1;
        push('0, "idle");
    endtask

    task automatic trap_cycles(input int n, input string t);
        out_t e;
        for (int i = 0; i < n; i++) begin
            e = base(); e.trap = 1;
            cyc(e, rb(), {t, ".trap"});
        end
    endtask

    // One instruction; w = memory wait cycles, stall = memory never answers within w
    task automatic run(input int k, input logic [3:0] aop, input logic [2:0] f3,
                       input logic [3:0] flg, input int w, input bit stall);
        out_t e;
        string t;
        t = nm[k];
        @(posedge clk); #1;
        set_type(k); alu_op = aop; funct3 = f3; fr = flg; mem_ready = rb();
        e = base(); e.pcw = 1; e.pc0w = 1; e.irw = 1; e.pcs = 2'b00;
        push(e, {t, ".fetch"});
        e = base(); e.done = (k == K_NOP) && !TRAP_EN;
        cyc(e, rb(), {t, ".decode"});
        case (k)
            K_R, K_I, K_AUIPC: begin
                e = base();
                e.alu = (k == K_AUIPC) ? 4'b0000 : aop;
                e.rs1 = (k == K_AUIPC); e.rs2 = (k != K_R);
                cyc(e, rb(), {t, ".exe"});
                e = base(); e.rw = 1; e.wd = 2'b00; e.done = 1;
                cyc(e, rb(), {t, ".wb"});
            end
            K_LUI: begin
                e = base(); e.rw = 1; e.wd = 2'b01; e.done = 1;
                cyc(e, rb(), {t, ".wb"});
            end
            K_JAL: begin
                e = base(); e.pcw = 1; e.rw = 1; e.wd = 2'b11; e.pcs = 2'b01; e.done = 1;
                cyc(e, rb(), {t, ".jump"});
            end
            K_LD, K_ST, K_JALR: begin
                e = base(); e.alu = 4'b0000; e.rs1 = 0; e.rs2 = 1;
                cyc(e, rb(), {t, ".addr"});
                if (k == K_JALR) begin
                    e = base(); e.pcw = 1; e.rw = 1; e.wd = 2'b11; e.pcs = 2'b10; e.done = 1;
                    cyc(e, rb(), {t, ".jump"});
                end else begin
                    for (int i = 0; i <= w; i++) begin
                        if (stall && i == w) break;
                        e = base(); e.mreq = 1; e.mwr = (k == K_ST);
                        e.done = (k == K_ST) && (i == w);
                        cyc(e, (i == w), {t, ".wait"});
                    end
                    if (stall) begin
                        if (TRAP_EN && w == TMO) trap_cycles(4, t);
                    end else if (k == K_LD) begin
                        e = base(); e.rw = 1; e.wd = 2'b10; e.done = 1;
                        cyc(e, rb(), {t, ".wb"});
                    end
                end
            end
            K_BR: begin
                e = base(); e.alu = 4'b1000; e.rs1 = 0; e.rs2 = 0;
                cyc(e, rb(), {t, ".cmp"});
                e = base(); e.pcs = 2'b01; e.pcw = br_taken(f3, flg); e.done = 1;
                cyc(e, rb(), {t, ".br"});
            end
            default: if (TRAP_EN) trap_cycles(3, t);
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        set_type(K_NOP); funct3 = 0; alu_op = 0; fr = 0; mem_ready = 0; m = '0;
        do_reset();
        run(K_R, 4'b0010, 3'd0, 4'h0, 0, 0);
        run(K_LD, 4'h3, 3'd0, 4'h0, 3, 0);
        run(K_BR, 4'h0, 3'b101, 4'b0101, 0, 0);
        run(K_BR, 4'h0, 3'b101, 4'b0100, 0, 0);
        run(K_AUIPC, 4'h7, 3'd0, 4'h0, 0, 0);
        run(K_LD, 4'h1, 3'd0, 4'h0, 3, 1);   // aborted by reset while waiting
        do_reset();
        run(K_ST, 4'h5, 3'd0, 4'h0, 0, 0);
        run(K_ST, 4'h5, 3'd0, 4'h0, 2, 0);
        run(K_LUI, 4'h9, 3'd0, 4'h0, 0, 0);
        run(K_JAL, 4'h9, 3'd0, 4'h0, 0, 0);
        run(K_JALR, 4'h9, 3'd0, 4'h0, 0, 0);
        run(K_I, 4'b0110, 3'd0, 4'h0, 0, 0);
        if (!TRAP_EN) run(K_NOP, 4'h0, 3'd0, 4'h0, 0, 0);
        for (int i = 0; i < 150; i++) begin
            k = TRAP_EN ? $urandom_range(0, 8) : $urandom_range(0, 9);
            run(k, 4'($urandom), 3'($urandom), 4'($urandom), $urandom_range(0, 4), 0);
        end
        if (TRAP_EN) begin
            run(K_ST, 4'h0, 3'd0, 4'h0, TMO, 1);
            do_reset();
            run(K_NOP, 4'h0, 3'd0, 4'h0, 0, 0);
            do_reset();
            run(K_R, 4'b0001, 3'd0, 4'h0, 0, 0);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cu_mc_ext.md
Name: cu_mc_ext

Overview:
- Parametrised multicycle control unit for the RV32I core; successor of the fixed-width CU FSM.
- Adds AUIPC, the full branch set (BEQ/BNE/BLT/BGE/BLTU/BGEU), a ready/valid handshake to variable-latency data memory, and a retire pulse.
- Sits between the decoder (one-hot type flags, funct3, ALU op) and the datapath (PC/PC0/IR/regfile/ALU muxes).

Parameters:
- ALU_OP_W, 4, width of ALU op code in/out.
- ALU_ADD, 4'b0000, op code driven for address, AUIPC and JALR-target computation.
- ALU_SUB, 4'b1000, op code driven for branch compare.
- MEM_TIMEOUT, 0, max data-memory wait cycles before trap; 0 = wait forever (used only with ILLEGAL_TRAP_EN).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- is_r, is_imm, is_lui, is_auipc, is_load, is_store, is_jal, is_jalr, is_branch  in  1 each  one-hot decoded type
- funct3  in  3  branch condition select
- alu_op  in  ALU_OP_W  ALU op from decoder
- fr  in  4  ALU flags {ZF,SF,CF,OF}; CF=1 means unsigned borrow (rs1<rs2)
- mem_ready  in  1  data memory completes request this cycle
- pc_write, pc0_write, ir_write, reg_write  out  1  datapath write enables
- mem_req  out  1  data memory request (held until mem_ready)
- mem_write  out  1  store qualifier, valid with mem_req
- rs1_pc_s  out  1  ALU A = PC0 (1) / rs1 (0)
- rs2_imm_s  out  1  ALU B = imm (1) / rs2 (0)
- w_data_s  out  2  00 ALU, 01 imm(LUI), 10 mem, 11 PC
- pc_s  out  2  00 PC+4, 01 PC0+imm, 10 ALU result
- alu_op_o  out  ALU_OP_W  op to ALU
- instr_done  out  1  one-cycle retire pulse
- trap  out  1  sticky; core halted (only with ILLEGAL_TRAP_EN)

Behaviour:
- Reset (async, rst_n=0): state IDLE, all outputs 0, alu_op_o=0. Asserting reset mid-instruction aborts it with no write enables left high. First FETCH is the cycle after release.
- Outputs are registered from Next_ST, so they are valid during the cycle the FSM sits in that state. Unlisted enables are 0; mux selects and alu_op_o hold their last value.
- States and outputs:
  - IDLE -> FETCH.
  - FETCH: pc_write, pc0_write, ir_write, pc_s=00. -> DECODE.
  - DECODE: no enables. Transition priority: lui -> LUI_WB; jal -> JAL; auipc -> AUIPC_EX; r -> EXE_R; imm -> EXE_I; branch -> BR_CMP; load/store/jalr -> ADDR; none -> FETCH (NOP).
  - EXE_R: alu_op_o=alu_op, rs1_pc_s=0, rs2_imm_s=0. -> WB_ALU.
  - EXE_I: same as EXE_R but rs2_imm_s=1. -> WB_ALU.
  - AUIPC_EX: alu_op_o=ALU_ADD, rs1_pc_s=1, rs2_imm_s=1. -> WB_ALU.
  - WB_ALU: reg_write, w_data_s=00. -> FETCH.
  - LUI_WB: reg_write, w_data_s=01. -> FETCH.
  - ADDR: alu_op_o=ALU_ADD, rs1_pc_s=0, rs2_imm_s=1. Exits: load -> LD_WAIT; store -> ST_WAIT; jalr -> JALR.
  - LD_WAIT: mem_req=1, mem_write=0. Stays until mem_ready, then -> LD_WB.
  - LD_WB: reg_write, w_data_s=10. -> FETCH.
  - ST_WAIT: mem_req=1, mem_write=1. On mem_ready -> FETCH.
  - JAL: pc_write, reg_write, w_data_s=11, pc_s=01. -> FETCH.
  - JALR: pc_write, reg_write, w_data_s=11, pc_s=10. -> FETCH.
  - BR_CMP: alu_op_o=ALU_SUB, rs1_pc_s=0, rs2_imm_s=0. -> BR_DO.
  - BR_DO: pc_s=01; pc_write=taken. -> FETCH.
- Branch condition (taken) by funct3: 000 ZF; 001 !ZF; 100 SF^OF; 101 !(SF^OF); 110 CF; 111 !CF; 010/011 not taken.
- mem_ready sampled only in LD_WAIT/ST_WAIT and ignored elsewhere. mem_ready already high on entry completes in 1 cycle.
- instr_done pulses for one cycle in the last state of each instruction (WB_ALU, LUI_WB, LD_WB, JAL, JALR, BR_DO, ST_WAIT on ready, DECODE-NOP).
- Cycle counts with mem_ready=1: R/I/AUIPC 4; LUI/JAL 3; LW 5; SW 4; JALR 4; branch 4.

Optional Feature:
- ILLEGAL_TRAP_EN defined:
  - DECODE with no type flag set -> TRAP state.
  - If MEM_TIMEOUT>0, a wait counter reaching MEM_TIMEOUT cycles in LD_WAIT/ST_WAIT -> TRAP.
  - In TRAP: trap=1, all enables 0; exit only via rst_n.
- Undefined: no-flag decode is a NOP (-> FETCH), no counter, trap tied 0.

Test Plan:
- Reset mid-LD_WAIT with mem_req=1, then release -> all outputs 0 immediately; next cycle FETCH with pc_write=ir_write=1.
- is_r, alu_op=4'b0010 -> FETCH, DECODE, EXE_R (alu_op_o=0010, rs2_imm_s=0), WB_ALU (reg_write=1, w_data_s=00, instr_done=1).
- is_load, mem_ready low for 3 cycles -> mem_req held 4 cycles, mem_write=0; LD_WB reg_write=1, w_data_s=10.
- is_branch, funct3=101, fr={ZF0,SF1,CF0,OF1} -> taken, pc_write=1, pc_s=01. Same with OF=0 -> pc_write=0.
- is_auipc -> AUIPC_EX with rs1_pc_s=1, rs2_imm_s=1, alu_op_o=0000; then WB_ALU reg_write=1.
- ILLEGAL_TRAP_EN, MEM_TIMEOUT=8, store with mem_ready stuck 0 -> trap=1 after 8 wait cycles, no further pc_write.
